reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 RS_SIZE, default 16, number of entries.
REQ-002 ROB_WID, default 4, ROB tag width; DATA_WID, default 32, operand width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rdy  in  1  global enable; when low, no state changes.
REQ-006 rollback  in  1  mispredict flush.
REQ-007 issue_valid  in  1  insert one instruction this cycle.
REQ-008 issue_opcode/issue_funct3/issue_funct7  in  7/3/1  decoded fields.
REQ-009 issue_val1, issue_val2  in  DATA_WID  operand values, meaningful when the matching dependency flag is clear.
REQ-010 issue_has_dep1, issue_has_dep2  in  1  operand still pending.
REQ-011 issue_dep1, issue_dep2  in  ROB_WID  producer ROB tags.
REQ-012 issue_imm, issue_pc  in  32  immediate and PC; issue_rob_pos  in  ROB_WID  destination tag.
REQ-013 alu_res_done, alu_res_rob_pos, alu_res_cal  in  1/ROB_WID/DATA_WID  ALU broadcast bus.
REQ-014 lsb_res_done, lsb_res_rob_pos, lsb_res_val  in  1/ROB_WID/DATA_WID  load/store broadcast bus.
REQ-015 rs_full  out  1  combinational; high when every entry is busy.
REQ-016 alu_en  out  1  registered dispatch strobe.
REQ-017 alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_rob_pos, alu_pc  out  registered  dispatched entry fields.

Function
REQ-018 Insertion SHALL go to the lowest-index free entry when issue_valid && rdy && !rollback; issue_valid while rs_full is illegal.
REQ-019 Entry state SHALL be busy, fields, has_dep1/2, dep1/2, val1/2; ready = busy && !has_dep1 && !has_dep2.
REQ-020 Wakeup: for each busy entry, a broadcast whose tag equals a pending dep SHALL clear that dep and capture the value that cycle; both buses checked every cycle, both operands independently.
REQ-021 Bypass: an inserting instruction whose dep matches a same-cycle broadcast SHALL be stored ready-side (dep cleared, value captured).
REQ-022 If both buses match the same tag (illegal from ROB), ALU bus SHALL take priority.
REQ-023 Dispatch SHALL select the lowest-index ready entry, free it, and register its fields on the outputs with alu_en=1 next edge; otherwise alu_en=0 and other outputs hold.
REQ-024 Latency: an entry inserted at edge N SHALL dispatch no earlier than edge N+1; an entry woken at edge N no earlier than N+1.
REQ-025 Insert and dispatch in one cycle SHALL both occur; a slot freed this cycle is not reusable until next cycle, so rs_full reflects registered busy bits only.
REQ-026 At most one dispatch per cycle.
REQ-027 rollback (with rdy) SHALL clear all busy bits and alu_en at the next edge, dropping any same-cycle insert.
REQ-028 rdy low SHALL freeze all registers, including alu_en.

Reset
REQ-029 rst_n low SHALL asynchronously clear all busy bits, alu_en, and all alu_* outputs to 0; rs_full=0 after reset.
REQ-030 Reset mid-operation SHALL discard all entries with no dispatch after release until a new insert.

Structure
REQ-031 DATA_WID, ADDR_WID, ROB_WID, RS_SIZE, and opcode constants SHALL live in the shared definitions package.
REQ-032 One sub-module, rs_select, SHALL provide lowest-index priority encoding (free slot and ready slot), instantiated twice.

Verification
REQ-033 Insert ADD, no deps, val1=5, val2=7 at edge 0 -> alu_en=1 at edge 1, alu_val1=5, alu_val2=7, entry freed.
REQ-034 Insert with has_dep1, dep1=3; ALU broadcast tag 3, value 0x10 two cycles later -> alu_en one edge after broadcast, alu_val1=0x10.
REQ-035 Insert with dep2=6 in same cycle as LSB broadcast tag 6, value 0xAB -> dispatch next edge, alu_val2=0xAB.
REQ-036 Fill 16 entries with blocked deps -> rs_full=1; broadcast frees all in index order, one per cycle, entry 0 first.
REQ-037 8 busy entries, assert rollback -> next edge rs_full=0, alu_en=0, no later dispatch.
REQ-038 Pending ready entry, rdy=0 for 3 cycles -> outputs frozen; dispatch at first edge with rdy=1.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared widths, sizes and opcode constants for the reservation station
package reservation_station_pkg;

  localparam int DATA_WID = 32;
  localparam int ADDR_WID = 32;
  localparam int ROB_WID  = 4;
  localparam int RS_SIZE  = 16;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Which broadcast bus, if any, resolves a pending operand this cycle
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSB
  } src_sel_t;

endpackage

// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - issue, broadcast and dispatch signals of the reservation station
interface reservation_station_if #(
  parameter int ROB_WID  = reservation_station_pkg::ROB_WID,
  parameter int DATA_WID = reservation_station_pkg::DATA_WID,
  parameter int ADDR_WID = reservation_station_pkg::ADDR_WID
);

  logic                issue_valid;
  logic [6:0]          issue_opcode;
  logic [2:0]          issue_funct3;
  logic                issue_funct7;
  logic [DATA_WID-1:0] issue_val1;
  logic [DATA_WID-1:0] issue_val2;
  logic                issue_has_dep1;
  logic                issue_has_dep2;
  logic [ROB_WID-1:0]  issue_dep1;
  logic [ROB_WID-1:0]  issue_dep2;
  logic [ADDR_WID-1:0] issue_imm;
  logic [ADDR_WID-1:0] issue_pc;
  logic [ROB_WID-1:0]  issue_rob_pos;

  logic                alu_res_done;
  logic [ROB_WID-1:0]  alu_res_rob_pos;
  logic [DATA_WID-1:0] alu_res_cal;
  logic                lsb_res_done;
  logic [ROB_WID-1:0]  lsb_res_rob_pos;
  logic [DATA_WID-1:0] lsb_res_val;

  logic                rs_full;
  logic                alu_en;
  logic [6:0]          alu_opcode;
  logic [2:0]          alu_funct3;
  logic                alu_funct7;
  logic [DATA_WID-1:0] alu_val1;
  logic [DATA_WID-1:0] alu_val2;
  logic [ADDR_WID-1:0] alu_imm;
  logic [ROB_WID-1:0]  alu_rob_pos;
  logic [ADDR_WID-1:0] alu_pc;

  modport master (
    output issue_valid, issue_opcode, issue_funct3, issue_funct7, issue_val1, issue_val2,
           issue_has_dep1, issue_has_dep2, issue_dep1, issue_dep2, issue_imm, issue_pc,
           issue_rob_pos, alu_res_done, alu_res_rob_pos, alu_res_cal, lsb_res_done,
           lsb_res_rob_pos, lsb_res_val,
    input  rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
           alu_imm, alu_rob_pos, alu_pc
  );

  modport slave (
    input  issue_valid, issue_opcode, issue_funct3, issue_funct7, issue_val1, issue_val2,
           issue_has_dep1, issue_has_dep2, issue_dep1, issue_dep2, issue_imm, issue_pc,
           issue_rob_pos, alu_res_done, alu_res_rob_pos, alu_res_cal, lsb_res_done,
           lsb_res_rob_pos, lsb_res_val,
    output rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
           alu_imm, alu_rob_pos, alu_pc
  );

endinterface

// File: rtl/reservation_station_select.sv
// rtl/reservation_station_select.sv - lowest-index priority encoder over a request vector
module rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the last hit written is the lowest set index
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - operand-waiting buffer with broadcast wakeup and in-order-by-index dispatch
module reservation_station #(
  parameter int RS_SIZE  = reservation_station_pkg::RS_SIZE,
  parameter int ROB_WID  = reservation_station_pkg::ROB_WID,
  parameter int DATA_WID = reservation_station_pkg::DATA_WID,
  parameter int ADDR_WID = reservation_station_pkg::ADDR_WID
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 rdy,
  input logic                 rollback,
  reservation_station_if.slave bus
);
  import reservation_station_pkg::*;

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]  busy;
  logic [RS_SIZE-1:0]  has_dep1;
  logic [RS_SIZE-1:0]  has_dep2;
  logic [ROB_WID-1:0]  dep1     [RS_SIZE];
  logic [ROB_WID-1:0]  dep2     [RS_SIZE];
  logic [DATA_WID-1:0] val1     [RS_SIZE];
  logic [DATA_WID-1:0] val2     [RS_SIZE];
  logic [6:0]          opcode_q [RS_SIZE];
  logic [2:0]          funct3_q [RS_SIZE];
  logic                funct7_q [RS_SIZE];
  logic [ADDR_WID-1:0] imm_q    [RS_SIZE];
  logic [ADDR_WID-1:0] pc_q     [RS_SIZE];
  logic [ROB_WID-1:0]  rob_q    [RS_SIZE];

  logic [RS_SIZE-1:0]  ready_vec;
  logic                free_valid;
  logic [IDX_W-1:0]    free_idx;
  logic                disp_valid;
  logic [IDX_W-1:0]    disp_idx;
  logic                ins_en;

  assign ready_vec   = busy & ~has_dep1 & ~has_dep2;
  assign bus.rs_full = &busy;
  assign ins_en      = bus.issue_valid && free_valid;

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
    .req   (~busy),
    .valid (free_valid),
    .idx   (free_idx)
  );

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_sel (
    .req   (ready_vec),
    .valid (disp_valid),
    .idx   (disp_idx)
  );

  // ALU bus wins when both buses carry the same tag
  function automatic src_sel_t snoop(input logic pending, input logic [ROB_WID-1:0] tag);
    if (pending && bus.alu_res_done && bus.alu_res_rob_pos == tag) return SRC_ALU;
    if (pending && bus.lsb_res_done && bus.lsb_res_rob_pos == tag) return SRC_LSB;
    return SRC_NONE;
  endfunction

  // Entry payload is only meaningful while busy, so it carries no reset
  always_ff @(posedge clk) begin
    if (rdy && !rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          case (snoop(has_dep1[i], dep1[i]))
            SRC_ALU: begin has_dep1[i] <= 1'b0; val1[i] <= bus.alu_res_cal; end
            SRC_LSB: begin has_dep1[i] <= 1'b0; val1[i] <= bus.lsb_res_val; end
            default: ;
          endcase
          case (snoop(has_dep2[i], dep2[i]))
            SRC_ALU: begin has_dep2[i] <= 1'b0; val2[i] <= bus.alu_res_cal; end
            SRC_LSB: begin has_dep2[i] <= 1'b0; val2[i] <= bus.lsb_res_val; end
            default: ;
          endcase
        end
      end
      if (ins_en) begin
        opcode_q[free_idx] <= bus.issue_opcode;
        funct3_q[free_idx] <= bus.issue_funct3;
        funct7_q[free_idx] <= bus.issue_funct7;
        imm_q[free_idx]    <= bus.issue_imm;
        pc_q[free_idx]     <= bus.issue_pc;
        rob_q[free_idx]    <= bus.issue_rob_pos;
        dep1[free_idx]     <= bus.issue_dep1;
        dep2[free_idx]     <= bus.issue_dep2;
        case (snoop(bus.issue_has_dep1, bus.issue_dep1))
          SRC_ALU: begin has_dep1[free_idx] <= 1'b0; val1[free_idx] <= bus.alu_res_cal; end
          SRC_LSB: begin has_dep1[free_idx] <= 1'b0; val1[free_idx] <= bus.lsb_res_val; end
          default: begin
            has_dep1[free_idx] <= bus.issue_has_dep1;
            val1[free_idx]     <= bus.issue_val1;
          end
        endcase
        case (snoop(bus.issue_has_dep2, bus.issue_dep2))
          SRC_ALU: begin has_dep2[free_idx] <= 1'b0; val2[free_idx] <= bus.alu_res_cal; end
          SRC_LSB: begin has_dep2[free_idx] <= 1'b0; val2[free_idx] <= bus.lsb_res_val; end
          default: begin
            has_dep2[free_idx] <= bus.issue_has_dep2;
            val2[free_idx]     <= bus.issue_val2;
          end
        endcase
      end
    end
  end

  // Free slot comes from registered busy, so it never aliases this cycle's dispatch slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy            <= '0;
      bus.alu_en      <= 1'b0;
      bus.alu_opcode  <= '0;
      bus.alu_funct3  <= '0;
      bus.alu_funct7  <= 1'b0;
      bus.alu_val1    <= '0;
      bus.alu_val2    <= '0;
      bus.alu_imm     <= '0;
      bus.alu_rob_pos <= '0;
      bus.alu_pc      <= '0;
    end else if (rdy) begin
      if (rollback) begin
        busy       <= '0;
        bus.alu_en <= 1'b0;
      end else begin
        bus.alu_en <= disp_valid;
        if (disp_valid) begin
          busy[disp_idx]  <= 1'b0;
          bus.alu_opcode  <= opcode_q[disp_idx];
          bus.alu_funct3  <= funct3_q[disp_idx];
          bus.alu_funct7  <= funct7_q[disp_idx];
          bus.alu_val1    <= val1[disp_idx];
          bus.alu_val2    <= val2[disp_idx];
          bus.alu_imm     <= imm_q[disp_idx];
          bus.alu_rob_pos <= rob_q[disp_idx];
          bus.alu_pc      <= pc_q[disp_idx];
        end
        if (ins_en) busy[free_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station against a behavioural model
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int N = RS_SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic rollback = 1'b0;

  always #5 clk = ~clk;

  reservation_station_if bus ();

  reservation_station dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  typedef struct {
    int          cyc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] v1, v2, imm;
    logic [3:0]  rob;
    logic [31:0] pc;
  } disp_t;

  typedef struct {
    bit          busy;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm, pc;
    logic [3:0]  rob;
    bit          hd1, hd2;
    logic [3:0]  d1, d2;
    logic [31:0] v1, v2;
  } ent_t;

  ent_t  m [N];
  disp_t exp_q [$];
  disp_t last;
  bit    last_en = 0;
  bit    exp_full = 0;
  bit    mon_on = 0;
  int    edge_cnt = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [142:0] pk(input disp_t x);
    return {x.op, x.f3, x.f7, x.v1, x.v2, x.imm, x.rob, x.pc};
  endfunction

  function automatic bit model_full();
    foreach (m[i]) if (!m[i].busy) return 0;
    return 1;
  endfunction

  // A pending operand is satisfied by whichever bus names its tag; ALU first
  function automatic void resolve(input bit hd, input logic [3:0] tag, input logic [31:0] v,
                                  output bit ohd, output logic [31:0] ov);
    ohd = hd;
    ov  = v;
    if (!hd) return;
    if (bus.alu_res_done && bus.alu_res_rob_pos == tag) begin
      ohd = 0; ov = bus.alu_res_cal;
    end else if (bus.lsb_res_done && bus.lsb_res_rob_pos == tag) begin
      ohd = 0; ov = bus.lsb_res_val;
    end
  endfunction

  task automatic model_step();
    int e  = edge_cnt + 1;
    int fr = -1;
    int rd = -1;
    disp_t d;
    if (!rdy) begin
      if (last_en) begin last.cyc = e; exp_q.push_back(last); end
      return;
    end
    if (rollback) begin
      foreach (m[i]) m[i].busy = 0;
      last_en = 0;
      return;
    end
    foreach (m[i]) begin
      if (!m[i].busy && fr < 0) fr = i;
      if (m[i].busy && !m[i].hd1 && !m[i].hd2 && rd < 0) rd = i;
    end
    foreach (m[i]) if (m[i].busy) begin
      resolve(m[i].hd1, m[i].d1, m[i].v1, m[i].hd1, m[i].v1);
      resolve(m[i].hd2, m[i].d2, m[i].v2, m[i].hd2, m[i].v2);
    end
    if (rd >= 0) begin
      d.cyc = e; d.op = m[rd].op; d.f3 = m[rd].f3; d.f7 = m[rd].f7;
      d.v1 = m[rd].v1; d.v2 = m[rd].v2; d.imm = m[rd].imm; d.rob = m[rd].rob; d.pc = m[rd].pc;
      exp_q.push_back(d);
      last = d; last_en = 1;
      m[rd].busy = 0;
    end else begin
      last_en = 0;
    end
    if (bus.issue_valid && fr >= 0) begin
      m[fr].busy = 1;
      m[fr].op = bus.issue_opcode; m[fr].f3 = bus.issue_funct3; m[fr].f7 = bus.issue_funct7;
      m[fr].imm = bus.issue_imm; m[fr].pc = bus.issue_pc; m[fr].rob = bus.issue_rob_pos;
      m[fr].d1 = bus.issue_dep1; m[fr].d2 = bus.issue_dep2;
      resolve(bus.issue_has_dep1, bus.issue_dep1, bus.issue_val1, m[fr].hd1, m[fr].v1);
      resolve(bus.issue_has_dep2, bus.issue_dep2, bus.issue_val2, m[fr].hd2, m[fr].v2);
    end
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.issue_has_dep1 = 0; bus.issue_has_dep2 = 0;
    bus.alu_res_done = 0; bus.lsb_res_done = 0;
    rdy = 1; rollback = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    exp_full = model_full();
    #1;
    idle();
  endtask

  task automatic put(input bit hd1, input logic [3:0] d1, input bit hd2, input logic [3:0] d2,
                     input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm);
    bus.issue_valid = 1; bus.issue_opcode = OP_REG; bus.issue_funct3 = 3'd0; bus.issue_funct7 = 1'b0;
    bus.issue_has_dep1 = hd1; bus.issue_dep1 = d1; bus.issue_has_dep2 = hd2; bus.issue_dep2 = d2;
    bus.issue_val1 = v1; bus.issue_val2 = v2; bus.issue_imm = imm;
    bus.issue_pc = 32'h1000 + imm; bus.issue_rob_pos = imm[3:0];
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  disp_t got;
  logic [142:0] act_v;

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      n_cmp++;
      if (bus.rs_full !== exp_full) begin
        n_bad++;
        $display("FAIL rs_full edge=%0d actual=%0b required=%0b", edge_cnt, bus.rs_full, exp_full);
      end
      act_v = {bus.alu_opcode, bus.alu_funct3, bus.alu_funct7, bus.alu_val1, bus.alu_val2,
               bus.alu_imm, bus.alu_rob_pos, bus.alu_pc};
      if (bus.alu_en === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_dispatch edge=%0d actual=%h required=none", edge_cnt, act_v);
        end else begin
          got = exp_q.pop_front();
          if (got.cyc != edge_cnt || act_v !== pk(got)) begin
            n_bad++;
            $display("FAIL dispatch edge=%0d actual=%h required(edge %0d)=%h",
                     edge_cnt, act_v, got.cyc, pk(got));
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
        got = exp_q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missing_dispatch edge=%0d actual=alu_en0 required=%h", edge_cnt, pk(got));
      end
    end
  end

  initial begin
    idle();
    bus.issue_opcode = '0; bus.issue_funct3 = '0; bus.issue_funct7 = 0;
    bus.issue_val1 = '0; bus.issue_val2 = '0; bus.issue_dep1 = '0; bus.issue_dep2 = '0;
    bus.issue_imm = '0; bus.issue_pc = '0; bus.issue_rob_pos = '0;
    bus.alu_res_rob_pos = '0; bus.alu_res_cal = '0; bus.lsb_res_rob_pos = '0; bus.lsb_res_val = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    chk("reset_alu_en", 64'(bus.alu_en), 0);
    chk("reset_rs_full", 64'(bus.rs_full), 0);
    chk("reset_alu_val1", 64'(bus.alu_val1), 0);
    chk("reset_alu_pc", 64'(bus.alu_pc), 0);
    chk("reset_alu_opcode", 64'(bus.alu_opcode), 0);
    @(posedge clk); #1;
    mon_on = 1;

    // simple ADD with both operands present
    put(0, 0, 0, 0, 5, 7, 1); tick(); tick();
    chk("add_en", 64'(bus.alu_en), 1);
    chk("add_val1", 64'(bus.alu_val1), 5);
    chk("add_val2", 64'(bus.alu_val2), 7);
    tick();
    chk("add_freed_en", 64'(bus.alu_en), 0);

    // ALU wakeup two cycles after insert
    put(1, 3, 0, 0, 0, 2, 2); tick(); tick();
    bus.alu_res_done = 1; bus.alu_res_rob_pos = 3; bus.alu_res_cal = 32'h10; tick();
    chk("wake_not_early", 64'(bus.alu_en), 0);
    tick();
    chk("wake_en", 64'(bus.alu_en), 1);
    chk("wake_val1", 64'(bus.alu_val1), 32'h10);

    // same-cycle LSB bypass on insert
    put(0, 0, 1, 6, 4, 0, 3);
    bus.lsb_res_done = 1; bus.lsb_res_rob_pos = 6; bus.lsb_res_val = 32'hAB; tick(); tick();
    chk("bypass_en", 64'(bus.alu_en), 1);
    chk("bypass_val2", 64'(bus.alu_val2), 32'hAB);

    // both buses carry one tag: ALU value taken
    put(1, 5, 0, 0, 0, 1, 4); tick();
    bus.alu_res_done = 1; bus.alu_res_rob_pos = 5; bus.alu_res_cal = 32'h111;
    bus.lsb_res_done = 1; bus.lsb_res_rob_pos = 5; bus.lsb_res_val = 32'h222; tick(); tick();
    chk("prio_val1", 64'(bus.alu_val1), 32'h111);
    tick();

    // fill every entry, then release them together
    for (int i = 0; i < N; i++) begin put(1, 9, 0, 0, 0, 0, i); tick(); end
    chk("fill_full", 64'(bus.rs_full), 1);
    bus.alu_res_done = 1; bus.alu_res_rob_pos = 9; bus.alu_res_cal = 32'h99; tick();
    for (int i = 0; i < N; i++) begin
      tick();
      chk("drain_order_imm", 64'(bus.alu_imm), 64'(i));
    end
    tick();

    // rollback with eight blocked entries
    for (int i = 0; i < 8; i++) begin put(1, 12, 0, 0, 0, 0, 32 + i); tick(); end
    rollback = 1; tick();
    chk("rollback_full", 64'(bus.rs_full), 0);
    chk("rollback_en", 64'(bus.alu_en), 0);
    bus.alu_res_done = 1; bus.alu_res_rob_pos = 12; tick();
    repeat (3) begin tick(); chk("rollback_no_disp", 64'(bus.alu_en), 0); end

    // freeze a ready entry for three cycles
    put(0, 0, 0, 0, 32'h77, 1, 5); tick();
    repeat (3) begin rdy = 0; tick(); chk("freeze_en", 64'(bus.alu_en), 0); end
    tick();
    chk("unfreeze_en", 64'(bus.alu_en), 1);
    chk("unfreeze_val1", 64'(bus.alu_val1), 32'h77);
    tick();

    // reset mid-operation discards pending work
    for (int i = 0; i < 3; i++) begin put(1, 14, 0, 0, 0, 0, 40 + i); tick(); end
    rst_n = 0; #1;
    chk("midreset_en", 64'(bus.alu_en), 0);
    chk("midreset_full", 64'(bus.rs_full), 0);
    foreach (m[i]) m[i].busy = 0;
    exp_q.delete(); last_en = 0; exp_full = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    bus.alu_res_done = 1; bus.alu_res_rob_pos = 14; tick();
    repeat (3) begin tick(); chk("midreset_no_disp", 64'(bus.alu_en), 0); end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 7) != 0);
      rollback = ($urandom_range(0, 79) == 0);
      if (!model_full() && $urandom_range(0, 1) == 1) begin
        bus.issue_valid = 1;
        bus.issue_opcode = ($urandom_range(0, 1) == 1) ? OP_REG : OP_IMM;
        bus.issue_funct3 = 3'($urandom_range(0, 7));
        bus.issue_funct7 = ($urandom_range(0, 1) == 1);
        bus.issue_val1 = $urandom; bus.issue_val2 = $urandom;
        bus.issue_has_dep1 = ($urandom_range(0, 2) == 0);
        bus.issue_has_dep2 = ($urandom_range(0, 2) == 0);
        bus.issue_dep1 = 4'($urandom_range(0, 15));
        bus.issue_dep2 = 4'($urandom_range(0, 15));
        bus.issue_imm = $urandom; bus.issue_pc = $urandom;
        bus.issue_rob_pos = 4'($urandom_range(0, 15));
      end
      bus.alu_res_done = ($urandom_range(0, 2) == 0);
      bus.alu_res_rob_pos = 4'($urandom_range(0, 15));
      bus.alu_res_cal = $urandom;
      bus.lsb_res_done = ($urandom_range(0, 2) == 0);
      bus.lsb_res_rob_pos = 4'($urandom_range(0, 15));
      bus.lsb_res_val = $urandom;
      tick();
    end

    // drain: wake every tag, then let dispatch empty the station
    for (int t = 0; t < 16; t++) begin
      bus.alu_res_done = 1; bus.alu_res_rob_pos = 4'(t); bus.alu_res_cal = 32'(t); tick();
    end
    repeat (2 * N + 4) tick();
    chk("drain_rs_full", 64'(bus.rs_full), 0);
    chk("drain_queue_empty", 64'(exp_q.size()), 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
